uriscv_irq_ctrl: RTL and testbench
==================================

# uriscv_irq_ctrl

Machine-level interrupt controller that collects up to NUM_IRQ external interrupt lines and drives the core's single external-interrupt request and ISR vector inputs. It latches sources as edge- or level-triggered, selects the highest-priority pending source, and runs a claim/complete handshake over a small register port. Only one source may be in service at a time, so the controller does not nest interrupts.

## Interface
- NUM_IRQ, 8: number of interrupt sources (1..31); source index = id.
- VECTOR_BASE, 32'h0000_0100: ISR vector for id 0.
- VECTOR_SHIFT, 2: vector = VECTOR_BASE + (id << VECTOR_SHIFT), 32-bit wrap.

- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- irq_i  in  NUM_IRQ  raw interrupt lines, already synchronous to clk_i.
- cfg_rd_i  in  1  register read strobe, one cycle.
- cfg_wr_i  in  1  register write strobe, one cycle.
- cfg_addr_i  in  5  byte address; bits [4:2] select the register.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, valid with cfg_ack_o.
- cfg_ack_o  out  1  access acknowledge.
- intr_o  out  1  interrupt request to the core.
- isr_vector_o  out  32  vector of the selected source.

## Operation
- Register map. Bits above NUM_IRQ read 0 and ignore writes.
  - 0x00 PENDING: read-only for level sources. Write-1-clear for edge sources.
  - 0x04 ENABLE: read/write.
  - 0x08 EDGE: read/write. 1 = rising-edge triggered, 0 = level.
  - 0x0C CLAIM/COMPLETE.
    - Read: returns {valid, 26'b0, id[4:0]} for the lowest-index source with pending & enable.
    - If valid, the read sets that source's INSERVICE bit and clears its pending bit when the source is edge-triggered.
    - valid = 0 gives data 0 and has no side effect.
    - Write of wdata[4:0] = id: clears INSERVICE[id]. A write naming a source not in service is ignored.
  - 0x10 INSERVICE: read-only mask.
  - 0x14–0x1C: read 0, writes ignored.
- Pending:
  - Level source: pending_q <= irq_i every cycle.
  - Edge source: set on irq_i & ~irq_prev_q. Cleared by W1C or by claim.
  - A set on the same cycle as a clear: set wins.
- Candidate = pending_q & ENABLE. Priority is fixed, lowest index first.
- intr_o = (candidate != 0) && (INSERVICE == 0). This is a registered output.
- isr_vector_o is registered from the selected id each cycle the request condition holds. It holds its last value otherwise.
- Changing EDGE on a source: pending clears and irq_prev_q reloads from irq_i, so no spurious edge occurs.
- The core masks via mstatus.MIE. This block has no global enable.

## Timing
- Reset values:
  - pending, ENABLE, EDGE, INSERVICE, irq_prev_q: 0.
  - intr_o: 0.
  - isr_vector_o: VECTOR_BASE.
  - cfg_ack_o: 0.
  - cfg_rdata_o: 0.
- Reset mid-operation aborts any claim in flight. No ack is issued for a strobe on the reset cycle.
- Edge source: irq_i rises in cycle N → pending_q = 1 in N+1 → intr_o = 1 in N+2.
- Level source: same 2-cycle latency. Deassertion drops intr_o 2 cycles later unless the source was already claimed.
- Config port:
  - Access in cycle N → cfg_ack_o = 1 and cfg_rdata_o valid in N+1, for one cycle.
  - Register side effects are visible in N+1.
  - cfg_rdata_o returns 0 when not acking.
  - cfg_rd_i and cfg_wr_i together: the write is performed, the read is ignored, and a single ack is issued.
- Claim in cycle N: INSERVICE updates at the N+1 edge, and intr_o deasserts in N+2.
- Complete in cycle N: intr_o may reassert in N+2 for the next candidate.
- Back-to-back accesses (strobe every cycle) are supported. Each access sees the state left by the previous one.

## Test plan
- Edge source:
  - Stimulus: ENABLE = 0x04, EDGE = 0x04, 1-cycle pulse on irq_i[2].
  - intr_o rises 2 cycles later; isr_vector_o = 0x108.
  - CLAIM read returns 0x8000_0002. PENDING = 0 and INSERVICE = 0x04.
  - intr_o falls 2 cycles after the claim. Completing id 2 leaves INSERVICE = 0.
- Priority:
  - Stimulus: levels on irq_i[5] and irq_i[1], both enabled.
  - Claim returns id 1. intr_o stays low while id 1 is in service.
  - After completing id 1, intr_o reasserts with isr_vector_o = 0x114, and the next claim returns id 5.
- Masking and empty claim:
  - Stimulus: irq_i[3] high with ENABLE = 0.
  - PENDING = 0x08 and intr_o = 0.
  - CLAIM read returns 0x0000_0000 and INSERVICE is unchanged.
- Collisions:
  - New rising edge on an edge source in the same cycle as its W1C: the pending bit stays 1.
  - Complete written for a source not in service (id 4): INSERVICE unchanged.
- Config port:
  - Simultaneous rd+wr to ENABLE with 0xFF (NUM_IRQ = 8): one ack, ENABLE = 0xFF.
  - Write 0xFFFF_FFFF to ENABLE: reads back 0x0000_00FF.
- Reset mid-operation:
  - Stimulus: assert rst_i while a source is in service with intr_o pending.
  - Next cycle all registers are 0, intr_o = 0, isr_vector_o = 0x100, and no ack is issued.

Source files
------------

// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl
// Machine-level external interrupt controller for the uriscv core.
//   - Latches up to NUM_IRQ sources as level- or rising-edge-triggered.
//   - Fixed priority: the lowest index among pending & enabled sources wins.
//   - Claim/complete handshake through a small register port. Only one source
//     may be in service at a time, so interrupts never nest.
//
// Parameters
//   NUM_IRQ      number of sources (1..31), source index == id
//   VECTOR_BASE  ISR vector for id 0
//   VECTOR_SHIFT vector = VECTOR_BASE + (id << VECTOR_SHIFT), 32-bit wrap
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   irq_i         raw interrupt lines, already synchronous to clk_i
//   cfg_rd_i      register read strobe (one cycle)
//   cfg_wr_i      register write strobe (one cycle), wins over cfg_rd_i
//   cfg_addr_i    byte address, bits [4:2] select the register
//   cfg_wdata_i   write data
//   cfg_rdata_o   read data, valid with cfg_ack_o, 0 otherwise
//   cfg_ack_o     access acknowledge, one cycle after the strobe
//   intr_o        registered interrupt request to the core
//   isr_vector_o  registered vector of the selected source
//
// Register map (word index = cfg_addr_i[4:2])
//   0 PENDING    level bits read-only, edge bits write-1-clear
//   1 ENABLE     read/write
//   2 EDGE       read/write, 1 = rising edge, 0 = level
//   3 CLAIM      read claims the best candidate, write of id completes it
//   4 INSERVICE  read-only
//   5..7         read 0, writes ignored
module uriscv_irq_ctrl #(
  parameter int unsigned NUM_IRQ      = 8,
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int unsigned VECTOR_SHIFT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cfg_rd_i,
  input  logic               cfg_wr_i,
  input  logic [4:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               cfg_ack_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o
);

  localparam logic [2:0] RegPending   = 3'd0;
  localparam logic [2:0] RegEnable    = 3'd1;
  localparam logic [2:0] RegEdge      = 3'd2;
  localparam logic [2:0] RegClaim     = 3'd3;
  localparam logic [2:0] RegInService = 3'd4;

  // State
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] insvc_q, insvc_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic               intr_q, intr_d;
  logic [31:0]        vector_q, vector_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;

  // Access decode; a simultaneous read and write performs only the write.
  logic               wr_en;
  logic               rd_en;
  logic [2:0]         reg_sel;
  logic [NUM_IRQ-1:0] wdata_irq;

  assign wr_en     = cfg_wr_i;
  assign rd_en     = cfg_rd_i & ~cfg_wr_i;
  assign reg_sel   = cfg_addr_i[4:2];
  assign wdata_irq = cfg_wdata_i[NUM_IRQ-1:0];

  // Address byte offset and the upper write-data bits carry no meaning.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_addr_i[1:0], cfg_wdata_i};

  // Candidate selection
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] cand_onehot;
  logic               cand_any;
  logic [4:0]         sel_id;

  assign cand        = pending_q & enable_q;
  // Isolate the lowest set bit: that is the highest-priority candidate.
  assign cand_onehot = cand & (~cand + NUM_IRQ'(1));
  assign cand_any    = |cand;

  always_comb begin
    sel_id = '0;
    // Walk downwards so the lowest index is the last (winning) assignment.
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_id = 5'(i);
      end
    end
  end

  logic claim_valid;
  assign claim_valid = rd_en && (reg_sel == RegClaim) && cand_any;

  // Complete: one-hot of the written id. Ids outside the source range match
  // nothing, and clearing a bit that is not in service is a no-op.
  logic [NUM_IRQ-1:0] complete_mask;

  always_comb begin
    complete_mask = '0;
    if (wr_en && (reg_sel == RegClaim)) begin
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        if (cfg_wdata_i[4:0] == 5'(i)) begin
          complete_mask[i] = 1'b1;
        end
      end
    end
  end

  // Register and pending next state
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] edge_chg;
  logic [NUM_IRQ-1:0] edge_clr;
  logic [NUM_IRQ-1:0] edge_set;

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    w1c_mask = '0;
    edge_chg = '0;

    if (wr_en) begin
      case (reg_sel)
        RegPending: w1c_mask = wdata_irq & edge_q;
        RegEnable:  enable_d = wdata_irq;
        RegEdge: begin
          edge_d   = wdata_irq;
          edge_chg = wdata_irq ^ edge_q;
        end
        default: ;
      endcase
    end

    insvc_d = insvc_q & ~complete_mask;
    if (claim_valid) begin
      insvc_d = insvc_d | cand_onehot;
    end

    // Edge sources: a fresh rising edge beats any clear in the same cycle.
    edge_clr  = w1c_mask | (claim_valid ? (cand_onehot & edge_q) : '0);
    edge_set  = irq_i & ~irq_prev_q;
    pending_d = (edge_q & ((pending_q & ~edge_clr) | edge_set)) | (~edge_q & irq_i);

    // Switching a source's trigger mode drops its pending state; irq_prev_q
    // tracks irq_i every cycle, so no phantom edge follows the switch.
    pending_d = pending_d & ~edge_chg;
  end

  // Read data and acknowledge
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_sel)
        RegPending:   rdata_d = 32'(pending_q);
        RegEnable:    rdata_d = 32'(enable_q);
        RegEdge:      rdata_d = 32'(edge_q);
        RegClaim: begin
          if (cand_any) begin
            rdata_d = {1'b1, 26'b0, sel_id};
          end
        end
        RegInService: rdata_d = 32'(insvc_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  assign ack_d = cfg_rd_i | cfg_wr_i;

  // Request and vector; the vector holds while no request is raised.
  always_comb begin
    intr_d   = cand_any && (insvc_q == '0);
    vector_d = vector_q;
    if (intr_d) begin
      vector_d = VECTOR_BASE + (32'(sel_id) << VECTOR_SHIFT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      insvc_q    <= '0;
      irq_prev_q <= '0;
      intr_q     <= 1'b0;
      vector_q   <= VECTOR_BASE;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      insvc_q    <= insvc_d;
      irq_prev_q <= irq_i;
      intr_q     <= intr_d;
      vector_q   <= vector_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_ack_o    = ack_q;
  assign intr_o       = intr_q;
  assign isr_vector_o = vector_q;

endmodule

// File: tb/tb_uriscv_irq_ctrl.sv
// Testbench for uriscv_irq_ctrl: a directed vector table with hand-derived
// expectations, followed by randomized traffic checked against a per-source
// behavioural model.
module tb_uriscv_irq_ctrl;

  localparam int          N     = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int unsigned SHIFT = 2;

  localparam logic [4:0] AP = 5'h00;  // PENDING
  localparam logic [4:0] AE = 5'h04;  // ENABLE
  localparam logic [4:0] AG = 5'h08;  // EDGE
  localparam logic [4:0] AC = 5'h0C;  // CLAIM / COMPLETE
  localparam logic [4:0] AS = 5'h10;  // INSERVICE

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          cfg_rd;
  logic          cfg_wr;
  logic [4:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          cfg_ack;
  logic          intr;
  logic [31:0]   isr_vec;

  always #5 clk = ~clk;

  uriscv_irq_ctrl #(
    .NUM_IRQ      (N),
    .VECTOR_BASE  (BASE),
    .VECTOR_SHIFT (SHIFT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_i        (irq),
    .cfg_rd_i     (cfg_rd),
    .cfg_wr_i     (cfg_wr),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_ack_o    (cfg_ack),
    .intr_o       (intr),
    .isr_vector_o (isr_vec)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one entry per source, rules applied source by source.
  // ---------------------------------------------------------------------------
  bit          m_pend [N];
  bit          m_en   [N];
  bit          m_edg  [N];
  bit          m_svc  [N];
  bit          m_prev [N];
  bit          m_intr;
  bit          m_ack;
  logic [31:0] m_vec;
  logic [31:0] m_rdata;

  function automatic logic [31:0] pack(input bit a [N]);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic model_step();
    int          sel;
    int          id;
    int          rsel;
    bit          busy;
    bit          clr   [N];
    bit          tog   [N];
    bit          n_pend[N];
    bit          n_en  [N];
    bit          n_edg [N];
    bit          n_svc [N];
    bit          nx_intr;
    bit          nx_ack;
    logic [31:0] nx_vec;
    logic [31:0] nx_rdata;

    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_edg[i] = 0; m_svc[i] = 0; m_prev[i] = 0;
      end
      m_intr  = 0;
      m_ack   = 0;
      m_vec   = BASE;
      m_rdata = '0;
    end else begin
      sel  = -1;
      busy = 0;
      for (int i = 0; i < N; i++) begin
        if (sel < 0 && m_pend[i] && m_en[i]) sel = i;
        if (m_svc[i]) busy = 1;
        clr[i] = 0;
        tog[i] = 0;
      end
      nx_intr  = (sel >= 0) && !busy;
      nx_vec   = nx_intr ? BASE + (32'(sel) << SHIFT) : m_vec;
      nx_ack   = cfg_rd || cfg_wr;
      nx_rdata = '0;
      n_en     = m_en;
      n_edg    = m_edg;
      n_svc    = m_svc;
      rsel     = int'(cfg_addr[4:2]);

      if (cfg_wr) begin
        case (rsel)
          0: for (int i = 0; i < N; i++) if (cfg_wdata[i] && m_edg[i]) clr[i] = 1;
          1: for (int i = 0; i < N; i++) n_en[i] = cfg_wdata[i];
          2: for (int i = 0; i < N; i++) begin
               n_edg[i] = cfg_wdata[i];
               tog[i]   = (cfg_wdata[i] != m_edg[i]);
             end
          3: begin
               id = int'(cfg_wdata[4:0]);
               if (id < N && m_svc[id]) n_svc[id] = 0;
             end
          default: ;
        endcase
      end else if (cfg_rd) begin
        case (rsel)
          0: nx_rdata = pack(m_pend);
          1: nx_rdata = pack(m_en);
          2: nx_rdata = pack(m_edg);
          3: if (sel >= 0) begin
               nx_rdata   = 32'h8000_0000 | 32'(sel);
               n_svc[sel] = 1;
               clr[sel]   = 1;
             end
          4: nx_rdata = pack(m_svc);
          default: ;
        endcase
      end

      for (int i = 0; i < N; i++) begin
        if (m_edg[i]) begin
          if (irq[i] && !m_prev[i]) n_pend[i] = 1;
          else if (clr[i])          n_pend[i] = 0;
          else                      n_pend[i] = m_pend[i];
        end else begin
          n_pend[i] = irq[i];
        end
        if (tog[i]) n_pend[i] = 0;
      end
      for (int i = 0; i < N; i++) m_prev[i] = irq[i];

      m_pend  = n_pend;
      m_en    = n_en;
      m_edg   = n_edg;
      m_svc   = n_svc;
      m_intr  = nx_intr;
      m_ack   = nx_ack;
      m_vec   = nx_vec;
      m_rdata = nx_rdata;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle and the outputs expected in the
  // following cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        intr;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic [7:0] q, input logic rd, input logic wr,
                     input logic [4:0] a, input logic [31:0] wd, input logic ack,
                     input logic [31:0] rdat, input logic it, input logic [31:0] v);
    vec_t e;
    e.rst = r; e.irq = q; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
    e.ack = ack; e.rdata = rdat; e.intr = it; e.vec = v;
    tbl.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin : watchdog
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; irq = '0; cfg_rd = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    //  rst irq    rd wr addr wdata          ack rdata          intr vec
    row(1, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h100);  // reset
    // Edge source 2
    row(0, 8'h00, 0, 1, AE, 32'h04,         1, 32'h0,          0, 32'h100);
    row(0, 8'h00, 0, 1, AG, 32'h04,         1, 32'h0,          0, 32'h100);
    row(0, 8'h04, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h100);  // pulse
    row(0, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          1, 32'h108);
    row(0, 8'h00, 1, 0, AC, 32'h0,          1, 32'h8000_0002,  1, 32'h108);  // claim
    row(0, 8'h00, 1, 0, AP, 32'h0,          1, 32'h0,          0, 32'h108);
    row(0, 8'h00, 1, 0, AS, 32'h0,          1, 32'h04,         0, 32'h108);
    row(0, 8'h00, 0, 1, AC, 32'h2,          1, 32'h0,          0, 32'h108);  // complete
    row(0, 8'h00, 1, 0, AS, 32'h0,          1, 32'h0,          0, 32'h108);
    // Priority between level sources 1 and 5
    row(0, 8'h00, 0, 1, AE, 32'h22,         1, 32'h0,          0, 32'h108);
    row(0, 8'h00, 0, 1, AG, 32'h00,         1, 32'h0,          0, 32'h108);
    row(0, 8'h22, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h108);
    row(0, 8'h22, 0, 0, AP, 32'h0,          0, 32'h0,          1, 32'h104);
    row(0, 8'h22, 1, 0, AC, 32'h0,          1, 32'h8000_0001,  1, 32'h104);
    row(0, 8'h20, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h104);
    row(0, 8'h20, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h104);
    row(0, 8'h20, 0, 1, AC, 32'h1,          1, 32'h0,          0, 32'h104);
    row(0, 8'h20, 0, 0, AP, 32'h0,          0, 32'h0,          1, 32'h114);
    row(0, 8'h20, 1, 0, AC, 32'h0,          1, 32'h8000_0005,  1, 32'h114);
    row(0, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h114);
    row(0, 8'h00, 0, 1, AC, 32'h4,          1, 32'h0,          0, 32'h114);  // not in service
    row(0, 8'h00, 1, 0, AS, 32'h0,          1, 32'h20,         0, 32'h114);
    row(0, 8'h00, 0, 1, AC, 32'h5,          1, 32'h0,          0, 32'h114);
    // Masked source 3 and empty claim
    row(0, 8'h08, 0, 1, AE, 32'h0,          1, 32'h0,          0, 32'h114);
    row(0, 8'h08, 1, 0, AP, 32'h0,          1, 32'h08,         0, 32'h114);
    row(0, 8'h08, 1, 0, AC, 32'h0,          1, 32'h0,          0, 32'h114);
    row(0, 8'h08, 1, 0, AS, 32'h0,          1, 32'h0,          0, 32'h114);
    // Config port: rd+wr together, write masking, unused address
    row(0, 8'h00, 1, 1, AE, 32'hFF,         1, 32'h0,          0, 32'h114);
    row(0, 8'h00, 1, 0, AE, 32'h0,          1, 32'hFF,         0, 32'h114);
    row(0, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h114);
    row(0, 8'h00, 0, 1, AE, 32'hFFFF_FFFF,  1, 32'h0,          0, 32'h114);
    row(0, 8'h00, 1, 0, AE, 32'h0,          1, 32'hFF,         0, 32'h114);
    row(0, 8'h00, 1, 0, 5'h18, 32'h0,       1, 32'h0,          0, 32'h114);
    // New edge on source 0 in the same cycle as its W1C
    row(0, 8'h00, 0, 1, AG, 32'h01,         1, 32'h0,          0, 32'h114);
    row(0, 8'h01, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h114);
    row(0, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          1, 32'h100);
    row(0, 8'h01, 0, 1, AP, 32'h01,         1, 32'h0,          1, 32'h100);
    row(0, 8'h00, 1, 0, AP, 32'h0,          1, 32'h01,         1, 32'h100);
    row(0, 8'h00, 0, 1, AP, 32'h01,         1, 32'h0,          1, 32'h100);
    row(0, 8'h00, 1, 0, AP, 32'h0,          1, 32'h0,          0, 32'h100);
    // Reset while source 6 is in service and level source 4 is pending
    row(0, 8'h00, 0, 1, AG, 32'h40,         1, 32'h0,          0, 32'h100);
    row(0, 8'h40, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h100);
    row(0, 8'h00, 0, 0, AP, 32'h0,          0, 32'h0,          1, 32'h118);
    row(0, 8'h00, 1, 0, AC, 32'h0,          1, 32'h8000_0006,  1, 32'h118);
    row(0, 8'h10, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h118);
    row(0, 8'h10, 0, 0, AP, 32'h0,          0, 32'h0,          0, 32'h118);
    row(1, 8'h10, 1, 0, AC, 32'h0,          0, 32'h0,          0, 32'h100);
    row(0, 8'h10, 1, 0, AS, 32'h0,          1, 32'h0,          0, 32'h100);
    row(0, 8'h00, 1, 0, AE, 32'h0,          1, 32'h0,          0, 32'h100);
    row(0, 8'h00, 1, 0, AG, 32'h0,          1, 32'h0,          0, 32'h100);
    row(0, 8'h00, 1, 0, AP, 32'h0,          1, 32'h0,          0, 32'h100);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; irq = tbl[i].irq; cfg_rd = tbl[i].rd; cfg_wr = tbl[i].wr;
      cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
      tick();
      check($sformatf("row%0d ack", i),   32'(cfg_ack), 32'(tbl[i].ack));
      check($sformatf("row%0d rdata", i), cfg_rdata,    tbl[i].rdata);
      check($sformatf("row%0d intr", i),  32'(intr),    32'(tbl[i].intr));
      check($sformatf("row%0d vec", i),   isr_vec,      tbl[i].vec);
    end

    // Randomized traffic against the model.
    rst = 1'b1; cfg_rd = 1'b0; cfg_wr = 1'b0; irq = '0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] rs;
      int         op;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq = N'($urandom & $urandom);
      op     = int'($urandom_range(0, 9));
      cfg_rd = (op < 3) || (op == 5);
      cfg_wr = (op >= 3) && (op <= 5);
      rs     = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      cfg_addr  = {rs, 2'($urandom_range(0, 3))};
      cfg_wdata = $urandom;
      if (rs == 3'd3) cfg_wdata[4:0] = 5'($urandom_range(0, 9));
      tick();
      check($sformatf("rnd%0d ack", c),   32'(cfg_ack), 32'(m_ack));
      check($sformatf("rnd%0d rdata", c), cfg_rdata,    m_rdata);
      check($sformatf("rnd%0d intr", c),  32'(intr),    32'(m_intr));
      check($sformatf("rnd%0d vec", c),   isr_vec,      m_vec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
